spi_master: RTL
===============

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter READ_WAIT, default 2, turnaround cycles between command shift-out and MISO sampling on a read-data frame; legal range 1..15.
REQ-002 clk  input  1  single clock; all state on posedge clk; also the serial bit clock shared with the slave.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to send one frame; accepted when ready=1.
REQ-005 cmd  input  10  frame word, MSB first; cmd[9:8]: 00 write-address, 01 write-data, 10 read-address, 11 read-data; cmd[7:0] payload.
REQ-006 ready  output  1  high when a start will be accepted this cycle.
REQ-007 busy  output  1  high while a frame is in progress (any state except IDLE).
REQ-008 done  output  1  one-cycle pulse at the end of every frame.
REQ-009 rx_byte  output  8  byte received on MISO; holds its value until the next read-data frame completes.
REQ-010 rx_valid  output  1  one-cycle pulse when rx_byte is updated.
REQ-011 SS_n  output  1  slave select, active low, registered.
REQ-012 MOSI  output  1  serial data to slave, registered.
REQ-013 MISO  input  1  serial data from slave, sampled on posedge clk.

Function
REQ-014 The FSM SHALL have the states IDLE, SEL, SHIFT, TURN, RDATA and GAP.
- IDLE: SS_n=1, MOSI=0. A start with ready=1 latches cmd into a shadow register; next state SEL.
- SEL: 1 cycle; SS_n=0, MOSI=cmd[9] (frame-type bit); next state SHIFT.
- SHIFT: 10 cycles; SS_n=0, MOSI=cmd[9-k] for k=0..9. Then TURN if cmd[9:8]=11, else GAP.
- TURN: READ_WAIT cycles; SS_n=0, MOSI=0; next state RDATA.
- RDATA: 8 cycles; SS_n=0, MOSI=0; MISO sampled each cycle into a shift register MSB first; then GAP.
- GAP: 1 cycle; SS_n=1, done=1; next state IDLE.
REQ-015 Cycle-level timing: if start is accepted at edge 0, SS_n SHALL be low from edge 1 through edge 11 for a non-read-data frame, with done high in the cycle after edge 12.
REQ-016 For a read-data frame, SS_n SHALL stay low for 11+READ_WAIT+8 cycles. rx_byte and rx_valid SHALL update in the same cycle as done.
REQ-017 The latched cmd SHALL be used for the whole frame; changes on cmd or start during a frame SHALL be ignored, except as given in REQ-022.
REQ-018 SS_n SHALL be high for at least one cycle between consecutive frames.
REQ-019 ready SHALL equal (state==IDLE) when SPI_MASTER_QUEUE_EN is undefined.
REQ-020 MISO SHALL be ignored outside RDATA.

Reset
REQ-021 While rst_n=0, the block SHALL go to IDLE immediately, with SS_n=1, MOSI=0, busy=0, done=0, rx_valid=0, rx_byte=0, ready=1 and the queue empty. Reset mid-frame SHALL abort the frame with no done pulse.

Configuration
REQ-022 Macro SPI_MASTER_QUEUE_EN:
- Defined: a one-entry command queue is added. ready=1 whenever the queue is empty, including during a frame.
- A start accepted while busy SHALL be stored in the queue. On leaving GAP, the FSM SHALL go directly to SEL with the queued cmd, which keeps the 1-cycle SS_n-high gap of REQ-018.
- A start accepted in IDLE with the queue empty SHALL bypass the queue.
- Undefined: no queue; starts while busy are dropped.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Write-address: start with cmd=10'h0A5 -> MOSI sequence 0, then 0,0,1,0,1,0,0,1,0,1; SS_n low 11 cycles; done at cycle 12; no rx_valid.
- Read-data, READ_WAIT=2: cmd=10'h300, slave drives 8'hC3 on MISO during RDATA -> SS_n low 21 cycles; rx_byte=8'hC3 with rx_valid and done in the same cycle.
- Back-to-back, queue enabled: second start (cmd=10'h1FF) issued during the first frame -> exactly one SS_n-high cycle between frames; two done pulses.
- Back-to-back, queue disabled: second start issued while busy -> dropped; only one frame seen on MOSI.
- rst_n asserted at the 5th SHIFT cycle -> SS_n=1 and MOSI=0 immediately; no done pulse; a new start after release runs a complete frame.
- MISO toggling during SHIFT and TURN -> rx_byte unaffected.

Source files
------------

// File: rtl/spi_master_if.sv
// Bus bundle for spi_master: frame request handshake, status, receive data and SPI pins.
interface spi_master_if;
  logic       start;
  logic [9:0] cmd;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  modport master (
    input  start, cmd, MISO,
    output ready, busy, done, rx_byte, rx_valid, SS_n, MOSI
  );

  modport slave (
    output start, cmd, MISO,
    input  ready, busy, done, rx_byte, rx_valid, SS_n, MOSI
  );
endinterface

// File: rtl/spi_master.sv
// SPI master sending 10-bit command frames; read-data frames return one byte from MISO.
// Optional one-entry command queue enabled by defining SPI_MASTER_QUEUE_EN.
module spi_master #(
  parameter int READ_WAIT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    SHIFT,
    TURN,
    RDATA,
    GAP
  } state_t;

  localparam logic [3:0] TURN_LAST  = 4'(READ_WAIT - 1);
  localparam logic [3:0] SHIFT_LAST = 4'd9;
  localparam logic [3:0] RDATA_LAST = 4'd7;
  localparam logic [1:0] TYPE_RDATA = 2'b11;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] type_q, type_d;
  logic [9:0] tx_q, tx_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_valid_q, rx_valid_d;
  logic       done_q, done_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic       ready;
  logic       accept;

`ifdef SPI_MASTER_QUEUE_EN
  logic       q_valid_q, q_valid_d;
  logic [9:0] q_cmd_q, q_cmd_d;

  assign ready = !q_valid_q;
`else
  assign ready = (state_q == IDLE);
`endif

  assign accept = bus.start && ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    type_d     = type_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    done_d     = 1'b0;
    ss_n_d     = 1'b0;
    mosi_d     = 1'b0;
`ifdef SPI_MASTER_QUEUE_EN
    q_valid_d  = q_valid_q;
    q_cmd_d    = q_cmd_q;
    // Starts arriving mid-frame park here; in IDLE they go straight to the shadow.
    if (accept && (state_q != IDLE)) begin
      q_valid_d = 1'b1;
      q_cmd_d   = bus.cmd;
    end
`endif

    unique case (state_q)
      IDLE: begin
        ss_n_d = 1'b1;
`ifdef SPI_MASTER_QUEUE_EN
        if (q_valid_q) begin
          q_valid_d = 1'b0;
          type_d    = q_cmd_q[9:8];
          tx_d      = q_cmd_q;
          state_d   = SEL;
        end else if (accept) begin
          type_d  = bus.cmd[9:8];
          tx_d    = bus.cmd;
          state_d = SEL;
        end
`else
        if (accept) begin
          type_d  = bus.cmd[9:8];
          tx_d    = bus.cmd;
          state_d = SEL;
        end
`endif
      end

      SEL: begin
        // Frame-type bit is presented early without consuming it from tx_q.
        mosi_d  = tx_q[9];
        cnt_d   = 4'd0;
        state_d = SHIFT;
      end

      SHIFT: begin
        mosi_d = tx_q[9];
        tx_d   = {tx_q[8:0], 1'b0};
        if (cnt_q == SHIFT_LAST) begin
          cnt_d   = 4'd0;
          state_d = (type_q == TYPE_RDATA) ? TURN : GAP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      TURN: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = 4'd0;
          state_d = RDATA;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      RDATA: begin
        rx_sh_d = {rx_sh_q[6:0], bus.MISO};
        if (cnt_q == RDATA_LAST) begin
          cnt_d   = 4'd0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      GAP: begin
        ss_n_d = 1'b1;
        done_d = 1'b1;
        if (type_q == TYPE_RDATA) begin
          rx_byte_d  = rx_sh_q;
          rx_valid_d = 1'b1;
        end
`ifdef SPI_MASTER_QUEUE_EN
        // A queued command chains directly; this GAP cycle is the SS_n-high separator.
        if (q_valid_q) begin
          q_valid_d = 1'b0;
          type_d    = q_cmd_q[9:8];
          tx_d      = q_cmd_q;
          state_d   = SEL;
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end

      default: begin
        ss_n_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      type_q     <= 2'b00;
      tx_q       <= 10'd0;
      rx_sh_q    <= 8'd0;
      rx_byte_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      type_q     <= type_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
    end
  end

`ifdef SPI_MASTER_QUEUE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid_q <= 1'b0;
      q_cmd_q   <= 10'd0;
    end else begin
      q_valid_q <= q_valid_d;
      q_cmd_q   <= q_cmd_d;
    end
  end
`endif

  assign bus.ready    = ready;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.rx_byte  = rx_byte_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.SS_n     = ss_n_q;
  assign bus.MOSI     = mosi_q;

endmodule
